// File: rtl/vram_pkg.sv
// Shared video RAM constants, colours and write scheduler state encoding.
package vram_pkg;

    localparam int VRAM_ADDR_WIDTH = 14;
    localparam int VRAM_DATA_WIDTH = 3;

    localparam logic [VRAM_DATA_WIDTH-1:0] BLACK  = 3'b000;
    localparam logic [VRAM_DATA_WIDTH-1:0] YELLOW = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester that did not win last.
module rr_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    always_comb begin
        grant0 = en && valid0 && (!valid1 || last_grant);
        grant1 = en && valid1 && (!valid0 || !last_grant);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/vram_wr_sched.sv
// Video RAM port A write scheduler: full-frame clear engine plus two requesters.
// Optional VRAM_WR_BLANK_ONLY_EN restricts all writes to video_on==0.
module vram_wr_sched
    import vram_pkg::*;
#(
    parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = VRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_color,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  video_on,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din
);

    localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = {ADDR_WIDTH{1'b1}};

    sched_state_e          state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] color;
    logic                  wr_ok;
    logic                  arb_en;
    logic                  g0;
    logic                  g1;

`ifdef VRAM_WR_BLANK_ONLY_EN
    assign wr_ok = !video_on;
`else
    logic unused_video_on;
    assign unused_video_on = video_on;
    assign wr_ok = 1'b1;
`endif

    // A clr_start in IDLE takes the port even if a requester is waiting.
    assign arb_en = (state == IDLE) && !clr_start && wr_ok;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (arb_en),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .grant0  (g0),
        .grant1  (g1)
    );

    assign req0_ready = g0;
    assign req1_ready = g1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            color    <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            clr_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        color    <= clr_color;
                        clr_busy <= 1'b1;
                    end else if (g0) begin
                        ram_we   <= 1'b1;
                        ram_addr <= req0_addr;
                        ram_din  <= req0_data;
                    end else if (g1) begin
                        ram_we   <= 1'b1;
                        ram_addr <= req1_addr;
                        ram_din  <= req1_data;
                    end
                end
                CLEAR: begin
                    if (wr_ok) begin
                        ram_we   <= 1'b1;
                        ram_addr <= cnt;
                        ram_din  <= color;
                        cnt      <= cnt + 1'b1;
                        if (cnt == CLEAR_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    clr_done <= 1'b1;
                    clr_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_wr_sched.sv
// Self-checking bench for vram_wr_sched: arbitration vectors and clear sequences.
module tb_vram_wr_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr_start = 1'b0;
    logic [2:0]  clr_color = '0;
    logic        clr_busy;
    logic        clr_done;
    logic        req0_valid = 1'b0;
    logic [13:0] req0_addr = '0;
    logic [2:0]  req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [13:0] req1_addr = '0;
    logic [2:0]  req1_data = '0;
    logic        req1_ready;
    logic        video_on = 1'b0;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [2:0]  ram_din;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_wr_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .video_on   (video_on),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din)
    );

    typedef struct {
        bit         rst;
        bit         v0;
        bit         v1;
        logic [13:0] a0;
        logic [2:0]  d0;
        logic [13:0] a1;
        logic [2:0]  d1;
        bit         r0;
        bit         r1;
    } vec_t;

    typedef struct {
        logic [13:0] addr;
        logic [2:0]  data;
    } wr_t;

    vec_t tv[9];
    wr_t  sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        clr_start  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        video_on   = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("reset_state",
            {ram_we, clr_busy, clr_done, req0_ready, req1_ready, ram_din, ram_addr},
            32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int e0;
        wr_t w;
        tv[0] = '{1, 1, 0, 14'h0081, 3'b101, 14'h0000, 3'b000, 1, 0};
        tv[1] = '{0, 0, 1, 14'h0000, 3'b000, 14'h3FFF, 3'b111, 0, 1};
        tv[2] = '{0, 0, 0, 14'h0000, 3'b000, 14'h0000, 3'b000, 0, 0};
        tv[3] = '{1, 1, 1, 14'h0100, 3'b001, 14'h0200, 3'b010, 1, 0};
        tv[4] = '{0, 1, 1, 14'h0100, 3'b001, 14'h0200, 3'b010, 0, 1};
        tv[5] = '{0, 1, 1, 14'h0100, 3'b001, 14'h0200, 3'b010, 1, 0};
        tv[6] = '{0, 1, 1, 14'h0100, 3'b001, 14'h0200, 3'b010, 0, 1};
        tv[7] = '{0, 1, 0, 14'h0000, 3'b000, 14'h0000, 3'b000, 1, 0};
        tv[8] = '{0, 1, 1, 14'h1234, 3'b011, 14'h2345, 3'b100, 0, 1};

        for (int i = 0; i < 9; i++) begin
            if (tv[i].rst) do_reset();
            req0_valid = tv[i].v0;
            req0_addr  = tv[i].a0;
            req0_data  = tv[i].d0;
            req1_valid = tv[i].v1;
            req1_addr  = tv[i].a1;
            req1_data  = tv[i].d1;
            #3;
            chk($sformatf("vec%0d_ready", i), {req0_ready, req1_ready},
                {tv[i].r0, tv[i].r1});
            if (tv[i].r0) sb.push_back('{tv[i].a0, tv[i].d0});
            if (tv[i].r1) sb.push_back('{tv[i].a1, tv[i].d1});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_we", i), ram_we, sb.size() > 0);
            if (sb.size() > 0) begin
                w = sb.pop_front();
                chk($sformatf("vec%0d_wr", i), {ram_din, ram_addr}, {w.data, w.addr});
            end
        end

        // Full clear, with a requester colliding with clr_start and waiting throughout.
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 14'h0055;
        req0_data  = 3'b011;
        req1_valid = 1'b0;
        clr_start  = 1'b1;
        clr_color  = 3'b110;
        #3;
        chk("clr_start_blocks_ready", req0_ready, 1'b0);
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        chk("clr_busy_rise", {clr_busy, ram_we}, 2'b10);
        for (int i = 0; i < 16384; i++) begin
            e0 = errors;
            if (i == 100) begin
                clr_start = 1'b1;
                clr_color = 3'b000;
            end else if (i == 16383) begin
                clr_start = 1'b1;
            end else begin
                clr_start = 1'b0;
            end
`ifndef VRAM_WR_BLANK_ONLY_EN
            video_on = i[3];
`endif
            @(posedge clk);
            #1;
            chk("clear_write",
                {ram_we, clr_busy, clr_done, req0_ready, ram_din, ram_addr},
                {4'b1100, 3'b110, i[13:0]});
            if (errors != e0) break;
        end
        clr_start = 1'b0;
        video_on  = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_done_pulse", {clr_done, clr_busy, ram_we}, 3'b100);
        #2;
        chk("ready_after_done", req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("clr_done_low", clr_done, 1'b0);
        chk("post_clear_write", {ram_we, ram_din, ram_addr}, {1'b1, 3'b011, 14'h0055});

        // Reset in the middle of a clear, then restart from address 0.
        do_reset();
        clr_start = 1'b1;
        clr_color = 3'b010;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        repeat (14'h1001) @(posedge clk);
        #1;
        chk("abort_point", {ram_we, ram_addr}, {1'b1, 14'h1000});
        reset_n = 1'b0;
        #1;
        chk("abort_async_we", {ram_we, clr_busy, clr_done}, 3'b000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {ram_we, clr_done, clr_busy}, 3'b000);
        end
        clr_start = 1'b1;
        clr_color = 3'b001;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        chk("restart_busy", clr_busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("restart_write", {ram_we, ram_din, ram_addr}, {1'b1, 3'b001, k[13:0]});
        end

`ifdef VRAM_WR_BLANK_ONLY_EN
        begin
            int nwr;
            bit seen_done;
            logic vo_prev;
            nwr = 0;
            seen_done = 1'b0;
            do_reset();
            clr_start = 1'b1;
            clr_color = 3'b100;
            video_on  = 1'b1;
            @(posedge clk);
            #1;
            clr_start = 1'b0;
            for (int c = 0; c < 40000; c++) begin
                video_on = ((c / 10) % 2) == 0;
                @(posedge clk);
                #1;
                vo_prev = video_on;
                if (ram_we) begin
                    e0 = errors;
                    chk("blank_write", {vo_prev, ram_din, ram_addr},
                        {1'b0, 3'b100, nwr[13:0]});
                    nwr++;
                    if (errors != e0) break;
                end
                if (clr_done) begin
                    seen_done = 1'b1;
                    break;
                end
            end
            video_on = 1'b0;
            chk("blank_total", nwr, 16384);
            chk("blank_done", seen_done, 1'b1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
